mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 136 +++++++++++++
 tb/tb_mem_copy_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Word-copy engine: streams len words from src to dst through a 4096x32 dual-port RAM
// (read on port A, write on port B). Optional running checksum under MEM_COPY_CHECKSUM_EN.
module mem_copy_engine (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] src_addr,
   input  logic [11:0] dst_addr,
   input  logic [12:0] len,
   output logic        busy,
   output logic        done,
   output logic [31:0] checksum,
   output logic [11:0] mem_addr_a,
   output logic        mem_we_a,
   output logic [31:0] mem_data_a,
   input  logic [31:0] mem_q_a,
   output logic [11:0] mem_addr_b,
   output logic        mem_we_b,
   output logic [31:0] mem_data_b,
   input  logic [31:0] mem_q_b
);

   typedef enum logic [1:0] {IDLE, COPY, DRAIN, FIN} state_t;

   state_t      state, state_n;
   logic [12:0] cnt, cnt_n;
   logic [12:0] len_q, len_n;
   logic [11:0] rd_addr_n;
   logic [11:0] wr_ptr, wr_ptr_n;
   logic [11:0] wr_addr_n;
   logic        we_n;
   logic        busy_n;
   logic        done_n;
   logic        accept;
   logic        unused_q_b;

   assign accept     = (state == IDLE) && start;
   assign unused_q_b = ^mem_q_b;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      len_n     = len_q;
      rd_addr_n = mem_addr_a;
      wr_ptr_n  = wr_ptr;
      wr_addr_n = mem_addr_b;
      we_n      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (len != 13'd0) begin
                  state_n   = COPY;
                  len_n     = len;
                  cnt_n     = 13'd1;
                  rd_addr_n = src_addr;
                  wr_ptr_n  = dst_addr;
               end else begin
                  state_n = FIN;
                  cnt_n   = '0;
               end
            end
         end
         COPY: begin
            // The read issued this cycle returns next cycle, so schedule its write now.
            we_n      = 1'b1;
            wr_addr_n = wr_ptr;
            wr_ptr_n  = wr_ptr + 12'd1;
            if (cnt == len_q) begin
               state_n = DRAIN;
            end else begin
               cnt_n     = cnt + 13'd1;
               rd_addr_n = mem_addr_a + 12'd1;
            end
         end
         DRAIN:   state_n = FIN;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy_n = (state_n == COPY) || (state_n == DRAIN);
   assign done_n = (state_n == FIN);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         len_q      <= '0;
         mem_addr_a <= '0;
         wr_ptr     <= '0;
         mem_addr_b <= '0;
         mem_we_b   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         cnt        <= cnt_n;
         len_q      <= len_n;
         mem_addr_a <= rd_addr_n;
         wr_ptr     <= wr_ptr_n;
         mem_addr_b <= wr_addr_n;
         mem_we_b   <= we_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

   assign mem_we_a   = 1'b0;
   assign mem_data_a = '0;

   // The RAM read port is already registered; forwarding its output keeps each write
   // one cycle behind its read. Gated so the bus idles at zero outside write cycles.
   assign mem_data_b = mem_we_b ? mem_q_a : '0;

`ifdef MEM_COPY_CHECKSUM_EN
   logic [31:0] sum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           sum_q <= '0;
      else if (accept)   sum_q <= '0;
      else if (mem_we_b) sum_q <= sum_q + mem_q_a;
   end

   assign checksum = sum_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign checksum      = '0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: RAM model, transaction-level reference model
// with a per-cycle compare process, and directed scenarios with hand-computed values.
module tb_mem_copy_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] src_addr = '0;
   logic [11:0] dst_addr = '0;
   logic [12:0] len = '0;
   logic        busy, done;
   logic [31:0] checksum;
   logic [11:0] mem_addr_a, mem_addr_b;
   logic        mem_we_a, mem_we_b;
   logic [31:0] mem_data_a, mem_data_b;
   logic [31:0] mem_q_a, mem_q_b;

   logic [31:0] ram  [4096];
   logic [31:0] snap [4096];
   bit          filled = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   mem_copy_engine dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .checksum(checksum),
      .mem_addr_a(mem_addr_a), .mem_we_a(mem_we_a), .mem_data_a(mem_data_a), .mem_q_a(mem_q_a),
      .mem_addr_b(mem_addr_b), .mem_we_b(mem_we_b), .mem_data_b(mem_data_b), .mem_q_b(mem_q_b)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pattern(input int i);
      if (i == 0) return 32'd1234;
      if (i == 1) return 32'd720;
      return (32'(i) * 32'h9E37_79B1) ^ 32'h0000_5A5A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                    name, act, act, exp, exp, $time);
   endtask

   // RAM with registered reads; contents survive reset.
   always @(posedge clk) begin
      if (!filled) begin
         for (int i = 0; i < 4096; i++) ram[i] <= pattern(i);
         filled <= 1'b1;
      end else begin
         mem_q_a <= ram[mem_addr_a];
         mem_q_b <= ram[mem_addr_b];
         if (mem_we_b) ram[mem_addr_b] <= mem_data_b;
      end
   end

   // Reference model: a job is accepted when start is seen while idle; m_cyc counts
   // cycles after the accept edge. Reads occupy cycles 1..len, writes 2..len+1, done len+2.
   bit          m_active = 1'b0;
   int          m_src = 0, m_dst = 0, m_len = 0, m_cyc = 0, m_done_cyc = 0;
   logic [31:0] m_sum = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_cyc    = 0;
         m_sum    = '0;
      end else if (m_active) begin
         if (m_cyc >= 2 && m_cyc <= m_len + 1) m_sum = m_sum + snap[(m_src + m_cyc - 2) % 4096];
         if (m_cyc == m_done_cyc) m_active = 1'b0;
         else                     m_cyc++;
      end else if (start) begin
         m_src      = int'(src_addr);
         m_dst      = int'(dst_addr);
         m_len      = int'(len);
         m_done_cyc = (m_len == 0) ? 1 : m_len + 2;
         m_cyc      = 1;
         m_sum      = '0;
         m_active   = 1'b1;
         snap       = ram;
      end
   end

   always @(negedge clk) begin
      bit exp_busy, exp_done, exp_we;
      if (rst) begin
         check("rst_busy", 32'(busy), 0);
         check("rst_done", 32'(done), 0);
         check("rst_we_b", 32'(mem_we_b), 0);
         check("rst_addr_a", 32'(mem_addr_a), 0);
         check("rst_addr_b", 32'(mem_addr_b), 0);
         check("rst_data_b", mem_data_b, 0);
         check("rst_checksum", checksum, 0);
      end else if (filled) begin
         exp_busy = m_active && m_len != 0 && m_cyc <= m_len + 1;
         exp_done = m_active && m_cyc == m_done_cyc;
         exp_we   = m_active && m_cyc >= 2 && m_cyc <= m_len + 1;
         check("busy", 32'(busy), 32'(exp_busy));
         check("done", 32'(done), 32'(exp_done));
         check("we_b", 32'(mem_we_b), 32'(exp_we));
         check("we_a", 32'(mem_we_a), 0);
         check("data_a", mem_data_a, 0);
`ifdef MEM_COPY_CHECKSUM_EN
         check("checksum", checksum, m_sum);
`else
         check("checksum", checksum, 0);
`endif
         if (m_active && m_cyc >= 1 && m_cyc <= m_len)
            check("addr_a", 32'(mem_addr_a), 32'((m_src + m_cyc - 1) % 4096));
         if (exp_we) begin
            check("addr_b", 32'(mem_addr_b), 32'((m_dst + m_cyc - 2) % 4096));
            check("data_b", mem_data_b, snap[(m_src + m_cyc - 2) % 4096]);
         end
         if (exp_done)
            for (int i = 0; i < m_len; i++)
               check("mem_contents", ram[(m_dst + i) % 4096], snap[(m_src + i) % 4096]);
      end
   end

   task automatic pulse_start(input int s, input int d, input int l);
      @(posedge clk); #1;
      start = 1'b1; src_addr = 12'(s); dst_addr = 12'(d); len = 13'(l);
      @(posedge clk); #1;
      start = 1'b0; src_addr = 12'hABC; dst_addr = 12'h123; len = 13'd5;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("done_within_budget", 32'(seen), 1);
   endtask

   initial begin
      int n_done;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 0);
      check("reset_checksum", checksum, 0);

      // Release reset with start already high: accepted on the very next edge.
      rst = 1'b0; start = 1'b1; src_addr = 12'd0; dst_addr = 12'd100; len = 13'd2;
      @(posedge clk); #1;
      start = 1'b0; src_addr = 12'hABC; dst_addr = 12'h123; len = 13'd5;
      @(negedge clk);
      check("c1_busy", 32'(busy), 1);
      check("c1_we_b", 32'(mem_we_b), 0);
      @(negedge clk);
      check("c2_we_b", 32'(mem_we_b), 1);
      check("c2_addr_b", 32'(mem_addr_b), 100);
      check("c2_data_b", mem_data_b, 1234);
      @(negedge clk);
      check("c3_addr_b", 32'(mem_addr_b), 101);
      check("c3_data_b", mem_data_b, 720);
      @(negedge clk);
      check("c4_done", 32'(done), 1);
      check("c4_busy", 32'(busy), 0);
`ifdef MEM_COPY_CHECKSUM_EN
      check("c4_checksum", checksum, 1954);
`else
      check("c4_checksum", checksum, 0);
`endif

      // Zero-length request finishes on the following cycle.
      pulse_start(30, 40, 0);
      @(negedge clk);
      check("len0_done", 32'(done), 1);
      check("len0_busy", 32'(busy), 0);
      check("len0_checksum", checksum, 0);
      @(negedge clk);
      check("len0_done_clear", 32'(done), 0);

      // Source wraps past 4095.
      pulse_start(4094, 10, 4);
      @(negedge clk); check("wrap_rd1", 32'(mem_addr_a), 4094);
      @(negedge clk); check("wrap_rd2", 32'(mem_addr_a), 4095);
      @(negedge clk); check("wrap_rd3", 32'(mem_addr_a), 0);
      @(negedge clk); check("wrap_rd4", 32'(mem_addr_a), 1);
      check("wrap_wr3_addr", 32'(mem_addr_b), 12);
      check("wrap_wr3_data", mem_data_b, 1234);
      wait_done(10);
      check("wrap_mem10", ram[10], pattern(4094));
      check("wrap_mem13", ram[13], 720);

      // Start pulsed mid-copy with other parameters is ignored.
      pulse_start(200, 300, 4);
      @(posedge clk); #1;
      start = 1'b1; src_addr = 12'd400; dst_addr = 12'd500; len = 13'd3;
      @(posedge clk); #1;
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("ignored_done_count", 32'(n_done), 1);
      check("ignored_mem500", ram[500], pattern(500));
      check("ignored_mem303", ram[303], pattern(203));

      // Reset in cycle 3 of an 8-word copy.
      pulse_start(600, 700, 8);
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_we_b", 32'(mem_we_b), 0);
      check("abort_addr_a", 32'(mem_addr_a), 0);
      repeat (2) @(posedge clk);
      #1;
      check("abort_mem700", ram[700], pattern(600));
      check("abort_mem701", ram[701], pattern(701));
      rst = 1'b0;
      pulse_start(600, 700, 8);
      wait_done(20);
      check("after_abort_mem707", ram[707], pattern(607));

      // Single word into the top address, then a whole-memory pass.
      pulse_start(4095, 2000, 1);
      wait_done(10);
      pulse_start(7, 7, 4096);
      wait_done(4200);
      @(posedge clk); #1;
      check("final_idle_busy", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
